// File: rtl/flow_ctrl.sv
// flow_ctrl: pipeline flow-control unit for the in-order core.
// Collects hazard and cache-miss events from ID, EX, Icache and Dcache and
// drives the back-and-keep (bk), jump and flush controls for IF and the
// IF/ID, ID/EX and EX/MEM pipeline registers.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ex_jump_flag_i/pc_i   EX-resolved taken branch/jump and its target
//   id_load_use_i         load-use hazard detected in ID
//   icache_miss_i/ready_i Icache miss and refill-complete
//   dcache_miss_i/ready_i Dcache miss and refill-complete
//   fc_bk_*_o             hold IF and the IF/ID, ID/EX, EX/MEM registers
//   fc_jump_flag_if_o     IF loads fc_jump_pc_if_o
//   fc_flush_id/ex_o      load a bubble into IF/ID, ID/EX
//
// Optional feature, macro FC_PERF_CNT_EN:
//   adds fc_stall_cnt_o (cycles with fc_bk_if_o=1) and fc_flush_cnt_o
//   (cycles with fc_jump_flag_if_o=1), both 32-bit wrapping counters.
//
// Outputs are combinational from state and inputs, and forced to 0 while
// rst_n is low.
module flow_ctrl #(
  parameter int unsigned PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_jump_flag_i,
  input  logic [PC_W-1:0] ex_jump_pc_i,
  input  logic            id_load_use_i,
  input  logic            icache_miss_i,
  input  logic            icache_ready_i,
  input  logic            dcache_miss_i,
  input  logic            dcache_ready_i,
  output logic            fc_bk_if_o,
  output logic            fc_jump_flag_if_o,
  output logic [PC_W-1:0] fc_jump_pc_if_o,
  output logic            fc_bk_id_o,
  output logic            fc_bk_ex_o,
  output logic            fc_bk_mem_o,
  output logic            fc_flush_id_o,
`ifdef FC_PERF_CNT_EN
  output logic            fc_flush_ex_o,
  output logic [31:0]     fc_stall_cnt_o,
  output logic [31:0]     fc_flush_cnt_o
`else
  output logic            fc_flush_ex_o
`endif
);

  typedef enum logic {RUN = 1'b0, I_WAIT = 1'b1} state_t;

  state_t          state, state_nxt;
  logic            d_busy, d_busy_nxt;
  logic            jp_valid, jp_valid_nxt;
  logic [PC_W-1:0] jp_pc, jp_pc_nxt;
  logic            freeze;

  logic            bk_if, bk_id, bk_ex, bk_mem;
  logic            jump_flag;
  logic [PC_W-1:0] jump_pc;
  logic            flush_id, flush_ex;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      d_busy   <= 1'b0;
      jp_valid <= 1'b0;
      jp_pc    <= '0;
    end else begin
      state    <= state_nxt;
      d_busy   <= d_busy_nxt;
      jp_valid <= jp_valid_nxt;
      jp_pc    <= jp_pc_nxt;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_nxt    = state;
    jp_valid_nxt = jp_valid;
    jp_pc_nxt    = jp_pc;
    bk_if        = 1'b0;
    bk_id        = 1'b0;
    bk_ex        = 1'b0;
    bk_mem       = 1'b0;
    jump_flag    = 1'b0;
    jump_pc      = '0;
    flush_id     = 1'b0;
    flush_ex     = 1'b0;

    // Freeze spans miss..ready inclusive; ready clears it at the end of that cycle.
    if (dcache_ready_i)     d_busy_nxt = 1'b0;
    else if (dcache_miss_i) d_busy_nxt = 1'b1;
    else                    d_busy_nxt = d_busy;

    freeze = d_busy | dcache_miss_i;

    if (freeze) begin
      // Whole pipe holds; a returning Icache fill still lands and is kept in IF/ID.
      bk_if  = 1'b1;
      bk_id  = 1'b1;
      bk_ex  = 1'b1;
      bk_mem = 1'b1;
      if (state == I_WAIT && icache_ready_i) state_nxt = RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (jp_valid) begin
            jump_flag    = 1'b1;
            jump_pc      = jp_pc;
            flush_id     = 1'b1;
            jp_valid_nxt = 1'b0;
          end else if (ex_jump_flag_i) begin
            jump_flag = 1'b1;
            jump_pc   = ex_jump_pc_i;
            flush_id  = 1'b1;
            flush_ex  = 1'b1;
          end else if (icache_miss_i) begin
            bk_if     = 1'b1;
            flush_id  = 1'b1;
            state_nxt = I_WAIT;
          end else if (id_load_use_i) begin
            bk_if    = 1'b1;
            bk_id    = 1'b1;
            flush_ex = 1'b1;
          end
        end
        I_WAIT: begin
          bk_if    = 1'b1;
          flush_id = 1'b1;
          // Redirect is buffered and issued once the fetch completes.
          if (ex_jump_flag_i) begin
            flush_ex     = 1'b1;
            jp_pc_nxt    = ex_jump_pc_i;
            jp_valid_nxt = 1'b1;
          end
          if (icache_ready_i) begin
            state_nxt = RUN;
            // Without a pending redirect the fetched instruction is wanted.
            if (!(jp_valid || ex_jump_flag_i)) begin
              bk_if    = 1'b0;
              flush_id = 1'b0;
            end
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // Outputs are quiet while reset is asserted
  assign fc_bk_if_o        = rst_n & bk_if;
  assign fc_bk_id_o        = rst_n & bk_id;
  assign fc_bk_ex_o        = rst_n & bk_ex;
  assign fc_bk_mem_o       = rst_n & bk_mem;
  assign fc_jump_flag_if_o = rst_n & jump_flag;
  assign fc_jump_pc_if_o   = (rst_n && jump_flag) ? jump_pc : '0;
  assign fc_flush_id_o     = rst_n & flush_id;
  assign fc_flush_ex_o     = rst_n & flush_ex;

`ifdef FC_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;

  // Performance counters, wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (fc_bk_if_o)        stall_cnt <= stall_cnt + 32'd1;
      if (fc_jump_flag_if_o) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign fc_stall_cnt_o = stall_cnt;
  assign fc_flush_cnt_o = flush_cnt;
`endif

endmodule

// File: tb/tb_flow_ctrl.sv
// Self-checking bench for flow_ctrl: a cycle-by-cycle vector table plus a
// hand-written mid-operation reset sequence.
module tb_flow_ctrl;

  localparam int unsigned PC_W = 32;

  logic            clk;
  logic            rst_n;
  logic            ex_jump_flag_i;
  logic [PC_W-1:0] ex_jump_pc_i;
  logic            id_load_use_i;
  logic            icache_miss_i;
  logic            icache_ready_i;
  logic            dcache_miss_i;
  logic            dcache_ready_i;
  logic            fc_bk_if_o;
  logic            fc_jump_flag_if_o;
  logic [PC_W-1:0] fc_jump_pc_if_o;
  logic            fc_bk_id_o;
  logic            fc_bk_ex_o;
  logic            fc_bk_mem_o;
  logic            fc_flush_id_o;
  logic            fc_flush_ex_o;
`ifdef FC_PERF_CNT_EN
  logic [31:0]     fc_stall_cnt_o;
  logic [31:0]     fc_flush_cnt_o;
`endif

  flow_ctrl #(.PC_W(PC_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ex_jump_flag_i    (ex_jump_flag_i),
    .ex_jump_pc_i      (ex_jump_pc_i),
    .id_load_use_i     (id_load_use_i),
    .icache_miss_i     (icache_miss_i),
    .icache_ready_i    (icache_ready_i),
    .dcache_miss_i     (dcache_miss_i),
    .dcache_ready_i    (dcache_ready_i),
    .fc_bk_if_o        (fc_bk_if_o),
    .fc_jump_flag_if_o (fc_jump_flag_if_o),
    .fc_jump_pc_if_o   (fc_jump_pc_if_o),
    .fc_bk_id_o        (fc_bk_id_o),
    .fc_bk_ex_o        (fc_bk_ex_o),
    .fc_bk_mem_o       (fc_bk_mem_o),
    .fc_flush_id_o     (fc_flush_id_o),
`ifdef FC_PERF_CNT_EN
    .fc_flush_ex_o     (fc_flush_ex_o),
    .fc_stall_cnt_o    (fc_stall_cnt_o),
    .fc_flush_cnt_o    (fc_flush_cnt_o)
`else
    .fc_flush_ex_o     (fc_flush_ex_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in : {jump, load_use, imiss, iready, dmiss, dready}
  // exp: {bk_if, jump_flag_if, bk_id, bk_ex, bk_mem, flush_id, flush_ex}
  typedef struct {
    logic [5:0]  in;
    logic [31:0] pc;
    logic [6:0]  exp;
    logic [31:0] exp_pc;
  } vec_t;

  localparam logic [5:0] I_J = 6'b100000, I_LU = 6'b010000, I_IM = 6'b001000,
                         I_IR = 6'b000100, I_DM = 6'b000010, I_DR = 6'b000001;
  localparam logic [6:0] E_0 = 7'b0000000, E_JMP = 7'b0100011, E_LU = 7'b1010001,
                         E_IW = 7'b1000010, E_IWJ = 7'b1000011, E_FRZ = 7'b1011100,
                         E_JPV = 7'b0100010;

  vec_t vecs[$];
  int   n_vec;
  int   n_fail;

  function automatic vec_t mk(logic [5:0] in, logic [31:0] pc, logic [6:0] exp,
                              logic [31:0] exp_pc);
    vec_t v;
    v.in = in; v.pc = pc; v.exp = exp; v.exp_pc = exp_pc;
    return v;
  endfunction

  task automatic drive(input logic [5:0] in, input logic [31:0] pc);
    {ex_jump_flag_i, id_load_use_i, icache_miss_i, icache_ready_i,
     dcache_miss_i, dcache_ready_i} = in;
    ex_jump_pc_i = pc;
  endtask

  task automatic check(input string name, input logic [6:0] exp, input logic [31:0] exp_pc);
    logic [6:0] act;
    act = {fc_bk_if_o, fc_jump_flag_if_o, fc_bk_id_o, fc_bk_ex_o, fc_bk_mem_o,
           fc_flush_id_o, fc_flush_ex_o};
    n_vec++;
    if (act !== exp || fc_jump_pc_if_o !== exp_pc) begin
      n_fail++;
      $display("FAIL %s: got ctl=%b pc=%h, want ctl=%b pc=%h",
               name, act, fc_jump_pc_if_o, exp, exp_pc);
    end
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    drive(6'b0, 32'h0);

    // Cycle-by-cycle sequence; each row depends on the state left by the previous.
    vecs.push_back(mk(6'b0,        32'h0,   E_0,   32'h0));   // idle
    vecs.push_back(mk(I_J,         32'h100, E_JMP, 32'h100)); // jump in RUN
    vecs.push_back(mk(6'b0,        32'h0,   E_0,   32'h0));
    vecs.push_back(mk(I_LU,        32'h0,   E_LU,  32'h0));   // load-use
    vecs.push_back(mk(6'b0,        32'h0,   E_0,   32'h0));
    vecs.push_back(mk(I_IM,        32'h0,   E_IW,  32'h0));   // icache miss
    vecs.push_back(mk(6'b0,        32'h0,   E_IW,  32'h0));
    vecs.push_back(mk(I_J,         32'h200, E_IWJ, 32'h0));   // jump buffered
    vecs.push_back(mk(6'b0,        32'h0,   E_IW,  32'h0));
    vecs.push_back(mk(6'b0,        32'h0,   E_IW,  32'h0));
    vecs.push_back(mk(I_IR,        32'h0,   E_IW,  32'h0));   // ready, discarded
    vecs.push_back(mk(6'b0,        32'h0,   E_JPV, 32'h200)); // pending redirect
    vecs.push_back(mk(6'b0,        32'h0,   E_0,   32'h0));
    vecs.push_back(mk(I_J | I_DM,  32'h300, E_FRZ, 32'h0));   // dmiss beats jump
    vecs.push_back(mk(I_J,         32'h300, E_FRZ, 32'h0));
    vecs.push_back(mk(I_J,         32'h300, E_FRZ, 32'h0));
    vecs.push_back(mk(I_J | I_DR,  32'h300, E_FRZ, 32'h0));   // ready still frozen
    vecs.push_back(mk(I_J,         32'h300, E_JMP, 32'h300)); // jump re-presented
    vecs.push_back(mk(6'b0,        32'h0,   E_0,   32'h0));
    vecs.push_back(mk(I_IM,        32'h0,   E_IW,  32'h0));   // miss, no jump
    vecs.push_back(mk(6'b0,        32'h0,   E_IW,  32'h0));
    vecs.push_back(mk(I_IR,        32'h0,   E_0,   32'h0));   // fetch accepted
    vecs.push_back(mk(I_LU,        32'h0,   E_LU,  32'h0));   // back in RUN
    vecs.push_back(mk(6'b0,        32'h0,   E_0,   32'h0));
    vecs.push_back(mk(I_IM,        32'h0,   E_IW,  32'h0));
    vecs.push_back(mk(I_IR | I_DM, 32'h0,   E_FRZ, 32'h0));   // ready + dmiss
    vecs.push_back(mk(I_DR,        32'h0,   E_FRZ, 32'h0));
    vecs.push_back(mk(6'b0,        32'h0,   E_0,   32'h0));   // RUN, not I_WAIT
    vecs.push_back(mk(I_IM,        32'h0,   E_IW,  32'h0));
    vecs.push_back(mk(I_J | I_IR,  32'h400, E_IWJ, 32'h0));   // jump with ready
    vecs.push_back(mk(6'b0,        32'h0,   E_JPV, 32'h400));
    vecs.push_back(mk(6'b0,        32'h0,   E_0,   32'h0));
    vecs.push_back(mk(I_J | I_IM,  32'h500, E_JMP, 32'h500)); // jump beats imiss
    vecs.push_back(mk(6'b0,        32'h0,   E_0,   32'h0));
    vecs.push_back(mk(I_J | I_LU,  32'h600, E_JMP, 32'h600)); // jump beats load-use
    vecs.push_back(mk(I_IM | I_LU, 32'h0,   E_IW,  32'h0));   // imiss beats load-use
    vecs.push_back(mk(I_IR,        32'h0,   E_0,   32'h0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("in_reset", E_0, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_release", E_0, 32'h0);
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].in, vecs[i].pc);
      @(negedge clk);
      check($sformatf("vec%0d", i), vecs[i].exp, vecs[i].exp_pc);
      @(posedge clk);
      #1;
    end

    // Reset mid-operation: enter I_WAIT, start a freeze, then assert reset.
    drive(I_IM, 32'h0);
    @(posedge clk); #1;
    drive(I_J | I_DM, 32'h700);
    @(posedge clk); #1;
    drive(I_J | I_IR | I_DR, 32'h700);
    rst_n = 1'b0;
    #1 check("async_reset_outputs", E_0, 32'h0);
    @(posedge clk); #1;
    drive(6'b0, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", E_0, 32'h0);
    @(posedge clk); #1;
    drive(I_LU, 32'h0);
    @(negedge clk);
    check("post_reset_run", E_LU, 32'h0);
    @(posedge clk); #1;
    drive(6'b0, 32'h0);

`ifdef FC_PERF_CNT_EN
    // Stall counter wraps from all-ones
    force dut.stall_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.stall_cnt;
    drive(I_LU, 32'h0);
    @(posedge clk); #1;
    drive(6'b0, 32'h0);
    n_vec++;
    if (fc_stall_cnt_o !== 32'h0) begin
      n_fail++;
      $display("FAIL stall_cnt_wrap: got %h, want 00000000", fc_stall_cnt_o);
    end
    force dut.flush_cnt = 32'h0000_0005;
    @(negedge clk);
    release dut.flush_cnt;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (fc_flush_cnt_o !== 32'h0 || fc_stall_cnt_o !== 32'h0) begin
      n_fail++;
      $display("FAIL cnt_reset: got stall=%h flush=%h, want 0",
               fc_stall_cnt_o, fc_flush_cnt_o);
    end
    rst_n = 1'b1;
`endif

    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/flow_ctrl.md
# flow_ctrl

Pipeline flow-control unit for the in-order core. Collects hazard and cache-miss events from ID, EX, Icache and Dcache, and drives the back-and-keep (bk), jump and flush controls for IF and the IF/ID, ID/EX and EX/MEM pipeline registers. It owns three pieces of state:
- the Icache-wait state machine;
- the Dcache freeze flag;
- a pending-jump buffer that holds a redirect arriving while a fetch is outstanding.

## Interface
Parameters:
- PC_W, 32, program-counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ex_jump_flag_i  in  1  EX resolved a taken branch/jump this cycle.
- ex_jump_pc_i  in  PC_W  redirect target, valid with ex_jump_flag_i.
- id_load_use_i  in  1  ID instruction depends on the load currently in EX.
- icache_miss_i  in  1  Icache cannot return the requested instruction this cycle.
- icache_ready_i  in  1  Icache refill complete; instruction valid this cycle.
- dcache_miss_i  in  1  Dcache miss on the MEM-stage access.
- dcache_ready_i  in  1  Dcache refill complete.
- fc_bk_if_o  out  1  IF holds pc and drops its request.
- fc_jump_flag_if_o  out  1  IF loads fc_jump_pc_if_o.
- fc_jump_pc_if_o  out  PC_W  redirect target to IF.
- fc_bk_id_o / fc_bk_ex_o / fc_bk_mem_o  out  1 each  hold IF/ID, ID/EX, EX/MEM registers.
- fc_flush_id_o / fc_flush_ex_o  out  1 each  load a bubble (NOP, valid=0) into IF/ID, ID/EX.

## Operation
State:
- fsm: RUN or I_WAIT.
- d_busy: 1 bit.
- jp_valid: 1 bit; jp_pc: PC_W bits.

Outputs are combinational from state and inputs. While rst_n=0, every output is 0.

d_busy (pipeline freeze):
- Set on dcache_miss_i. Cleared on the cycle dcache_ready_i=1.
- While d_busy=1, or dcache_miss_i=1: fc_bk_if/id/ex/mem=1 and all flushes=0.
- Jump, load-use and Icache events are ignored; EX is frozen, so a jump re-presents after the freeze.
- fsm does not advance, except that icache_ready_i is still captured: I_WAIT goes to RUN and the fetched instruction is held in IF/ID.

RUN, priority high to low (no freeze):
1. jp_valid=1:
   - fc_jump_flag_if=1, fc_jump_pc_if=jp_pc.
   - fc_flush_id=1.
   - jp_valid cleared.
2. ex_jump_flag_i=1:
   - fc_jump_flag_if=1, fc_jump_pc_if=ex_jump_pc_i.
   - fc_flush_id=1, fc_flush_ex=1 (two wrong-path instructions removed).
3. icache_miss_i=1:
   - fc_bk_if=1, fc_flush_id=1.
   - Go to I_WAIT.
4. id_load_use_i=1:
   - fc_bk_if=1, fc_bk_id=1, fc_flush_ex=1.
   - Exactly one bubble; the signal deasserts once the load advances.
5. Otherwise: all outputs 0.

I_WAIT:
- Each cycle: fc_bk_if=1, fc_flush_id=1.
- ex_jump_flag_i=1: fc_flush_ex=1; jp_pc<=ex_jump_pc_i, jp_valid<=1. A later jump overwrites, since it is younger on the correct path only if the first was not taken; EX is flushed, so there is at most one.
- icache_ready_i=1: go to RUN.
  - If jp_valid=1 or a jump arrives this same cycle: the returned instruction is discarded (fc_flush_id=1), and the redirect issues the next cycle from RUN rule 1.
  - Otherwise: fc_bk_if=0 and fc_flush_id=0, and the instruction enters IF/ID.

Other rules:
- fc_jump_pc_if_o = 0 whenever fc_jump_flag_if_o=0.
- jp_valid is never set in RUN.

## Timing
- Jump: ex_jump_flag_i high in cycle N, no pending state → IF pc = target after edge N. Target instruction in ID at N+2 (hit).
- Jump during I_WAIT: redirect issues one cycle after icache_ready_i.
- Load-use costs 1 cycle. Icache miss costs (ready cycle − miss cycle) bubbles. Dcache miss freezes for miss..ready inclusive.
- Async reset, mid-operation:
  - fsm=RUN, d_busy=0, jp_valid=0, jp_pc=0.
  - Outstanding cache responses are ignored until the first post-reset cycle.
- Simultaneous icache_ready_i and dcache_miss_i: the freeze wins, fsm goes to RUN, and IF/ID holds the instruction.

## Configuration
FC_PERF_CNT_EN:
- Defined:
  - Adds fc_stall_cnt_o (out, 32): increments every cycle fc_bk_if_o=1.
  - Adds fc_flush_cnt_o (out, 32): increments every cycle fc_jump_flag_if_o=1.
  - Both reset to 0 and wrap at 2^32−1 → 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset release with all inputs 0 → every output 0; fsm=RUN, jp_valid=0.
- ex_jump_flag_i=1, ex_jump_pc_i=0x0000_0100 for one cycle in RUN → the same cycle shows fc_jump_flag_if=1, pc=0x100, flush_id=1, flush_ex=1; next cycle all outputs 0.
- id_load_use_i high 1 cycle → bk_if=1, bk_id=1, flush_ex=1 for exactly 1 cycle.
- icache_miss_i, then icache_ready_i 5 cycles later; jump to 0x200 in cycle 2 of the wait → flush_ex=1 at the jump; bk_if+flush_id for all 6 cycles; then 1 cycle of jump_flag_if=1, pc=0x200, flush_id=1.
- dcache_miss_i and ex_jump_flag_i asserted together, dcache_ready_i 3 cycles later → 4 cycles with all bk=1 and no jump; the jump is taken in the cycle after ready while EX still presents it.
- FC_PERF_CNT_EN defined: counters preloaded to 0xFFFF_FFFF by force, then one stall cycle → fc_stall_cnt_o=0; reset mid-count → 0.
